// File: rtl/stepper_motor_control_integrator_pkg.sv
// Shared types and helpers for the stepper motion integrator and its step generator.
package stepper_motor_control_pkg;

  localparam int X_WIDTH_DEF = 48;
  localparam int Q_WIDTH_DEF = 16;
  localparam int STEP_WIDTH  = X_WIDTH_DEF - Q_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } step_state_t;

  // Add two signed values and clamp the sum to [-lim, +lim].
  // Operands are carried at 64 bits so the sum can never overflow before the clamp.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input logic        [63:0] lim);
    logic signed [63:0] sum;
    logic signed [63:0] lim_s;
    sum   = a + b;
    lim_s = signed'(lim);
    if (sum > lim_s)       return lim_s;
    else if (sum < -lim_s) return -lim_s;
    else                   return sum;
  endfunction

endpackage

// File: rtl/stepper_motor_control_integrator_step_gen.sv
// Step/DIR pulse generator: chases the integer position target one step at a
// time, respecting the DIR setup time and the STEP high/low minimum widths.
module stepper_motor_step_gen
  import stepper_motor_control_pkg::*;
#(
  parameter int STEP_W      = STEP_WIDTH,
  parameter int PULSE_WIDTH = 100,
  parameter int DIR_SETUP   = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_cke,
  input  logic                     i_load,
  input  logic signed [STEP_W-1:0] i_load_val,
  input  logic signed [STEP_W-1:0] i_tgt,
  output logic                     o_step,
  output logic                     o_dir,
  output logic signed [STEP_W-1:0] o_step_pos,
  output logic                     o_busy
);

  localparam logic [31:0] PW_LAST = 32'(PULSE_WIDTH - 1);
  localparam logic [31:0] SU_LAST = 32'(DIR_SETUP - 1);
  localparam logic signed [STEP_W-1:0] ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  step_state_t               r_state, w_state_nx;
  logic [31:0]               r_cnt, w_cnt_nx;
  logic                      r_step, w_step_nx;
  logic                      r_dir, w_dir_nx;
  logic signed [STEP_W-1:0]  r_pos, w_pos_nx;
  logic signed [STEP_W-1:0]  w_diff, w_pos_inc;
  logic                      w_nd, w_nz, w_go_step, w_go_setup;

  // Wrap-aware distance to target; its sign picks the direction.
  assign w_diff     = i_tgt - r_pos;
  assign w_nd       = w_diff[STEP_W-1];
  assign w_nz       = (w_diff != '0);
  assign w_pos_inc  = w_nd ? (r_pos - ONE) : (r_pos + ONE);
  assign w_go_step  = w_nz && (w_nd == r_dir);
  assign w_go_setup = w_nz && (w_nd != r_dir);

  // State and output registers; everything frozen while cke is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_pos   <= '0;
    end else if (i_cke) begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_step  <= w_step_nx;
      r_dir   <= w_dir_nx;
      r_pos   <= w_pos_nx;
    end
  end

  // Next-state logic. A position load never launches a step: decisions that
  // could start one are deferred while the load strobe is present.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_step_nx  = r_step;
    w_dir_nx   = r_dir;
    w_pos_nx   = r_pos;
    unique case (r_state)
      ST_IDLE: begin
        if (!i_load) begin
          if (w_go_step) begin
            w_step_nx  = 1'b1;
            w_pos_nx   = w_pos_inc;
            w_cnt_nx   = '0;
            w_state_nx = ST_HIGH;
          end else if (w_go_setup) begin
            w_dir_nx   = w_nd;
            w_cnt_nx   = '0;
            w_state_nx = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (r_cnt == SU_LAST) begin
          if (!i_load) begin
            if (!w_nz) begin
              w_state_nx = ST_IDLE;
            end else if (w_go_step) begin
              w_step_nx  = 1'b1;
              w_pos_nx   = w_pos_inc;
              w_cnt_nx   = '0;
              w_state_nx = ST_HIGH;
            end else begin
              w_dir_nx = w_nd;
              w_cnt_nx = '0;
            end
          end
        end else begin
          w_cnt_nx = r_cnt + 32'd1;
        end
      end
      ST_HIGH: begin
        if (r_cnt == PW_LAST) begin
          w_step_nx  = 1'b0;
          w_cnt_nx   = '0;
          w_state_nx = ST_LOW;
        end else begin
          w_cnt_nx = r_cnt + 32'd1;
        end
      end
      ST_LOW: begin
        if (r_cnt == PW_LAST) begin
          // Chain straight into the next pulse so the peak rate is one step
          // per 2*PULSE_WIDTH cycles.
          w_cnt_nx   = '0;
          w_state_nx = ST_IDLE;
          if (!i_load && w_go_step) begin
            w_step_nx  = 1'b1;
            w_pos_nx   = w_pos_inc;
            w_state_nx = ST_HIGH;
          end else if (!i_load && w_go_setup) begin
            w_dir_nx   = w_nd;
            w_state_nx = ST_SETUP;
          end
        end else begin
          w_cnt_nx = r_cnt + 32'd1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (i_load) w_pos_nx = i_load_val;
  end

  assign o_step     = r_step;
  assign o_dir      = r_dir;
  assign o_step_pos = r_pos;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: rtl/stepper_motor_control_integrator.sv
// Acceleration -> velocity -> fixed-point position integrator with a STEP/DIR
// pulse generator chasing the integer part of the position.
module stepper_motor_control_integrator
  import stepper_motor_control_pkg::*;
#(
  parameter int X_WIDTH     = 48,
  parameter int V_WIDTH     = 16,
  parameter int A_WIDTH     = 16,
  parameter int Q_WIDTH     = 16,
  parameter int PULSE_WIDTH = 100,
  parameter int DIR_SETUP   = 50
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cke,
  input  logic                              enable,
  input  logic [V_WIDTH-1:0]                max_v,
  input  logic signed [A_WIDTH:0]           in_a,
  input  logic                              in_valid,
  input  logic                              set_x,
  input  logic signed [X_WIDTH-1:0]         set_x_value,
  output logic signed [X_WIDTH-1:0]         cur_x,
  output logic signed [V_WIDTH:0]           cur_v,
  output logic signed [X_WIDTH-Q_WIDTH-1:0] step_pos,
  output logic                              step,
  output logic                              dir,
  output logic                              busy
);

  localparam int STEP_W = X_WIDTH - Q_WIDTH;

  logic signed [X_WIDTH-1:0] r_x;
  logic signed [V_WIDTH:0]   r_v;
  logic signed [V_WIDTH:0]   w_vn;
  logic [63:0]               w_lim;
  logic signed [STEP_W-1:0]  w_tgt;
  logic signed [STEP_W-1:0]  w_load_val;

  // New velocity, clamped to the symmetric limit before narrowing.
  assign w_lim = 64'(max_v);
  assign w_vn  = (V_WIDTH+1)'(sat_add(64'(r_v), 64'(in_a), w_lim));

  // Velocity/position integration; load has priority, disable bleeds velocity.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_v <= '0;
    end else if (cke) begin
      if (set_x) begin
        r_x <= set_x_value;
        r_v <= '0;
      end else if (!enable) begin
        r_v <= '0;
      end else if (in_valid) begin
        r_v <= w_vn;
        r_x <= r_x + X_WIDTH'(w_vn);
      end
    end
  end

  assign w_tgt      = r_x[X_WIDTH-1:Q_WIDTH];
  assign w_load_val = set_x_value[X_WIDTH-1:Q_WIDTH];

  stepper_motor_step_gen #(
    .STEP_W      (STEP_W),
    .PULSE_WIDTH (PULSE_WIDTH),
    .DIR_SETUP   (DIR_SETUP)
  ) u_step_gen (
    .clk        (clk),
    .reset      (reset),
    .i_cke      (cke),
    .i_load     (set_x),
    .i_load_val (w_load_val),
    .i_tgt      (w_tgt),
    .o_step     (step),
    .o_dir      (dir),
    .o_step_pos (step_pos),
    .o_busy     (busy)
  );

  assign cur_x = r_x;
  assign cur_v = r_v;

endmodule

// File: tb/tb_stepper_motor_control_integrator.sv
// Bench for stepper_motor_control_integrator: behavioural position/velocity
// model checked every cycle, a pulse-timing monitor, table-driven saturation
// vectors, directed multi-cycle sequences and a randomized phase.
module tb_stepper_motor_control_integrator;

  localparam int PW = 100;
  localparam int DS = 50;

  logic               clk = 1'b0;
  logic               reset, cke, enable, in_valid, set_x;
  logic [15:0]        max_v;
  logic signed [16:0] in_a;
  logic signed [47:0] set_x_value;
  logic signed [47:0] cur_x;
  logic signed [16:0] cur_v;
  logic signed [31:0] step_pos;
  logic               step, dir, busy;

  int     n_chk = 0;
  int     n_fail = 0;
  int     rises = 0;
  bit     chk_en = 1'b0;
  longint mx = 0, mv = 0;

  stepper_motor_control_integrator dut (
    .clk(clk), .reset(reset), .cke(cke), .enable(enable), .max_v(max_v),
    .in_a(in_a), .in_valid(in_valid), .set_x(set_x), .set_x_value(set_x_value),
    .cur_x(cur_x), .cur_v(cur_v), .step_pos(step_pos), .step(step),
    .dir(dir), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap48(input longint v);
    return (v <<< 16) >>> 16;
  endfunction

  function automatic longint vnext(input longint v, input longint a, input longint m);
    longint s;
    s = v + a;
    if (s > m) s = m;
    if (s < -m) s = -m;
    return s;
  endfunction

  // Reference model of velocity/position, advanced on every active edge.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      mx = 0; mv = 0;
    end else if (cke) begin
      if (set_x) begin
        mx = longint'(set_x_value); mv = 0;
      end else if (!enable) begin
        mv = 0;
      end else if (in_valid) begin
        mv = vnext(mv, longint'(in_a), longint'(max_v));
        mx = wrap48(mx + mv);
      end
    end
  end

  // Per-cycle model comparison plus STEP/DIR timing rules.
  initial begin
    bit     pstep, pdir;
    int     hi, lo, since;
    longint ppos;
    pstep = 0; pdir = 0; hi = 0; lo = 1000; since = 1000; ppos = 0;
    forever begin
      @(negedge clk);
      if (chk_en && !reset) begin
        chk("cur_x_model", cur_x, mx);
        chk("cur_v_model", cur_v, mv);
      end
      if (reset) begin
        pstep = 0; pdir = 0; hi = 0; lo = 1000; since = 1000; ppos = 0;
      end else begin
        if (dir != pdir) begin
          chk("dir_change_during_pulse", longint'(step | pstep), 0);
          since = 0;
        end else begin
          since++;
        end
        if (step && !pstep) begin
          chk("step_low_time_ok", longint'(lo >= PW), 1);
          chk("dir_setup_ok", longint'(since >= DS), 1);
          chk("step_pos_increment", step_pos, ppos + (dir ? -1 : 1));
          hi = 1;
          rises++;
        end else if (!step && pstep) begin
          chk("step_high_time_ok", longint'(hi >= PW), 1);
          lo = 1;
        end else if (step) begin
          hi++;
        end else begin
          lo++;
        end
        pstep = step; pdir = dir; ppos = step_pos;
      end
    end
  end

  task automatic pulse_a(input int a);
    in_a = 17'(a);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin n++; @(negedge clk); end
    chk(name, longint'(busy), 0);
  endtask

  typedef struct {
    int a;
    int maxv;
    int exp_v;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int   n, high, low, r0, bcnt;
    longint xs;

    tbl[0] = '{600, 1000, 600};
    tbl[1] = '{600, 1000, 1000};
    tbl[2] = '{-3000, 1000, -1000};
    tbl[3] = '{200, 1000, -800};
    tbl[4] = '{0, 300, -300};
    tbl[5] = '{65535, 65535, 65235};
    tbl[6] = '{65535, 65535, 65535};
    tbl[7] = '{-65535, 65535, 0};
    tbl[8] = '{-65535, 65535, -65535};
    tbl[9] = '{-65535, 65535, -65535};

    reset = 1; cke = 1; enable = 0; in_valid = 0; set_x = 0;
    max_v = 0; in_a = 0; set_x_value = 0;

    // Reset for 3 cycles, then idle.
    repeat (3) @(negedge clk);
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_cur_x", cur_x, 0);
    chk("rst_cur_v", cur_v, 0);
    chk("rst_step_pos", step_pos, 0);
    chk("rst_step", longint'(step), 0);
    chk("rst_dir", longint'(dir), 0);
    chk("rst_busy", longint'(busy), 0);
    r0 = rises; bcnt = 0;
    repeat (1000) begin @(negedge clk); if (busy) bcnt++; end
    chk("idle_no_steps", rises - r0, 0);
    chk("idle_no_busy", bcnt, 0);

    // Constant velocity: 16 updates of 4096 reach one full step.
    max_v = 16'hFFFF; enable = 1;
    pulse_a(4096);
    chk("first_v", cur_v, 4096);
    chk("first_x", cur_x, 4096);
    for (int k = 2; k <= 16; k++) begin
      repeat (9) @(negedge clk);
      pulse_a(0);
      chk("ramp_x", cur_x, 4096 * k);
    end
    chk("x_one_step", cur_x, 65536);
    @(negedge clk);
    chk("step_rise_latency", longint'(step), 1);
    chk("step1_dir", longint'(dir), 0);
    chk("step1_pos", step_pos, 1);
    high = 0;
    while (step && high < 1000) begin high++; @(negedge clk); end
    chk("step1_high_cycles", high, 100);
    wait_idle("step1_idle", 400);

    // Load -1 step: no pulse, step_pos follows the load.
    set_x = 1; set_x_value = -48'sd65536;
    @(negedge clk);
    set_x = 0;
    chk("load_cur_v", cur_v, 0);
    chk("load_cur_x", cur_x, -65536);
    chk("load_step_pos", step_pos, -1);
    bcnt = 0; r0 = rises;
    repeat (200) begin @(negedge clk); if (busy) bcnt++; end
    chk("load_no_pulse", rises - r0 + bcnt, 0);

    // Move one step negative: DIR rises, STEP follows DIR_SETUP cycles later.
    pulse_a(-65535);
    enable = 0;
    n = 0;
    while (!dir && n < 10) begin n++; @(negedge clk); end
    chk("neg_dir_rises", longint'(dir), 1);
    n = 0;
    while (!step && n < 500) begin n++; @(negedge clk); end
    chk("dir_to_step_cycles", n, 50);
    chk("neg_step_pos", step_pos, -2);

    // Load 30 cycles into HIGH: pulse keeps full timing.
    high = 0;
    while (step && high < 1000) begin
      set_x = (high == 30);
      set_x_value = 48'sd327803;
      high++;
      @(negedge clk);
    end
    set_x = 0;
    chk("load_mid_high_cycles", high, 100);
    low = 0;
    while (busy && !step && low < 1000) begin low++; @(negedge clk); end
    chk("load_mid_low_cycles", low, 100);
    chk("load_mid_step_pos", step_pos, 5);
    chk("load_mid_busy", longint'(busy), 0);

    // cke low for 40 cycles in the middle of HIGH.
    enable = 1;
    pulse_a(65535);
    enable = 0;
    n = 0;
    while (!step && n < 300) begin n++; @(negedge clk); end
    chk("cke_step_started", longint'(step), 1);
    high = 0;
    repeat (20) begin high++; @(negedge clk); end
    xs = cur_x;
    cke = 0; enable = 1; in_valid = 1; in_a = 17'sd1000;
    repeat (40) begin high++; @(negedge clk); end
    chk("cke_low_x_frozen", cur_x, xs);
    cke = 1; enable = 0; in_valid = 0; in_a = 0;
    while (step && high < 1000) begin high++; @(negedge clk); end
    chk("cke_stretched_high", high, 140);
    wait_idle("cke_idle", 400);

    // Saturation table.
    enable = 1;
    for (int i = 0; i < 10; i++) begin
      max_v = 16'(tbl[i].maxv);
      pulse_a(tbl[i].a);
      chk($sformatf("tbl_v[%0d]", i), cur_v, tbl[i].exp_v);
    end
    enable = 0;

    // Randomized phase.
    max_v = 16'(4000);
    for (int c = 0; c < 3000; c++) begin
      cke = ($urandom_range(0, 15) != 0);
      enable = ($urandom_range(0, 63) != 0);
      in_valid = ($urandom_range(0, 5) == 0);
      in_a = 17'(int'($urandom_range(0, 16000)) - 8000);
      set_x = ($urandom_range(0, 499) == 0);
      set_x_value = 48'(mx + longint'($urandom_range(0, 2097152)) - 1048576);
      if (c % 200 == 0) max_v = 16'($urandom_range(0, 8000));
      @(negedge clk);
    end
    cke = 1; enable = 0; in_valid = 0; set_x = 0;
    n = 0;
    while (!(busy == 0 && step_pos == cur_x[47:16]) && n < 30000) begin
      n++; @(negedge clk);
    end
    chk("rand_settled", longint'(step_pos), longint'(cur_x) >>> 16);
    chk("rand_idle", longint'(busy), 0);

    // Reset in the middle of a pulse.
    enable = 1;
    max_v = 16'hFFFF;
    pulse_a(65535);
    enable = 0;
    n = 0;
    while (!step && n < 400) begin n++; @(negedge clk); end
    chk("pre_reset_step", longint'(step), 1);
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_step", longint'(step), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_dir", longint'(dir), 0);
    chk("midrst_pos", step_pos, 0);
    chk("midrst_x", cur_x, 0);
    chk("midrst_v", cur_v, 0);
    reset = 0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
